// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and parity helper for the loadable instruction memory
package imem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } imem_state_e;

   localparam logic [15:0] NOP_DEFAULT = 16'h0000;

   // Even parity: stored bit makes the XOR of {parity, data} zero.
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/imem_loadable_if.sv
// rtl/imem_loadable_if.sv - program-load stream and fetch port bundle for imem_loadable
interface imem_loadable_if #(
   parameter int ISIZE  = 16,
   parameter int ADDR_W = 8
);
   logic              ld_start;
   logic              ld_valid;
   logic              ld_ready;
   logic [ISIZE-1:0]  ld_data;
   logic              ld_last;
   logic              ld_ovf;
   logic [ADDR_W:0]   words_loaded;
   logic              busy;
   logic              fetch_valid;
   logic              fetch_ready;
   logic [ADDR_W-1:0] fetch_addr;
   logic [ISIZE-1:0]  rdata;
   logic              rvalid;
   logic              fetch_err;

   modport master (
      output ld_start, ld_valid, ld_data, ld_last, fetch_valid, fetch_addr,
      input  ld_ready, ld_ovf, words_loaded, busy, fetch_ready, rdata, rvalid, fetch_err
   );

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last, fetch_valid, fetch_addr,
      output ld_ready, ld_ovf, words_loaded, busy, fetch_ready, rdata, rvalid, fetch_err
   );
endinterface

// File: rtl/imem_array.sv
// rtl/imem_array.sv - single-port synchronous RAM; read data register updates only on reads
module imem_array #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i[AW-1:0]] <= wdata_i;
      end else if (re_i) begin
         rdata_q <= mem[addr_i[AW-1:0]];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - run-time loadable instruction memory with clear sweep; IMEM_PARITY_EN adds per-word parity
module imem_loadable
   import imem_pkg::*;
#(
   parameter int               ISIZE    = 16,
   parameter int               ADDR_W   = 8,
   parameter int               DEPTH    = 256,
   parameter logic [ISIZE-1:0] NOP_WORD = ISIZE'(NOP_DEFAULT)
) (
   input  logic          clk,
   input  logic          rst,
   imem_loadable_if.slave bus
);
`ifdef IMEM_PARITY_EN
   localparam int MW = ISIZE + 1;
`else
   localparam int MW = ISIZE;
`endif

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   imem_state_e       state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              next_is_load_q, next_is_load_d;
   logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
   logic              ld_ovf_q, ld_ovf_d;
   logic              rvalid_q, rvalid_d;
   // Forces rdata to NOP_WORD: set by reset and by out-of-range fetches.
   logic              oob_q, oob_d;

   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [ISIZE-1:0]  wdata_raw;
   logic [MW-1:0]     mem_wdata, mem_rdata;
   logic              par_err;
   logic              ld_fire, fetch_fire, fetch_oob;

   assign ld_fire    = bus.ld_valid & (state_q == ST_LOAD);
   assign fetch_fire = bus.fetch_valid & (state_q == ST_RUN);
   assign fetch_oob  = {1'b0, bus.fetch_addr} >= DEPTH_W;

   always_comb begin
      state_d        = state_q;
      clr_ptr_d      = clr_ptr_q;
      next_is_load_d = next_is_load_q;
      words_loaded_d = words_loaded_q;
      ld_ovf_d       = ld_ovf_q;
      rvalid_d       = fetch_fire;
      oob_d          = oob_q;
      mem_we         = 1'b0;
      mem_re         = 1'b0;
      mem_addr       = bus.fetch_addr;
      wdata_raw      = NOP_WORD;

      if (fetch_fire) begin
         oob_d  = fetch_oob;
         mem_re = ~fetch_oob;
      end

      case (state_q)
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clr_ptr_q;
            if (clr_ptr_q == LAST_ADDR) begin
               clr_ptr_d      = '0;
               next_is_load_d = 1'b0;
               state_d        = next_is_load_q ? ST_LOAD : ST_RUN;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         ST_LOAD: begin
            if (ld_fire) begin
               if (words_loaded_q == DEPTH_W) begin
                  ld_ovf_d = 1'b1;
               end else begin
                  mem_we         = 1'b1;
                  mem_addr       = words_loaded_q[ADDR_W-1:0];
                  wdata_raw      = bus.ld_data;
                  words_loaded_d = words_loaded_q + 1'b1;
               end
               if (bus.ld_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (bus.ld_start) begin
               ld_ovf_d       = 1'b0;
               words_loaded_d = '0;
               next_is_load_d = 1'b1;
               state_d        = ST_CLEAR;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_CLEAR;
         clr_ptr_q      <= '0;
         next_is_load_q <= 1'b0;
         words_loaded_q <= '0;
         ld_ovf_q       <= 1'b0;
         rvalid_q       <= 1'b0;
         oob_q          <= 1'b1;
      end else begin
         state_q        <= state_d;
         clr_ptr_q      <= clr_ptr_d;
         next_is_load_q <= next_is_load_d;
         words_loaded_q <= words_loaded_d;
         ld_ovf_q       <= ld_ovf_d;
         rvalid_q       <= rvalid_d;
         oob_q          <= oob_d;
      end
   end

`ifdef IMEM_PARITY_EN
   assign mem_wdata = {even_parity(64'(wdata_raw)), wdata_raw};
   assign par_err   = ^mem_rdata;
`else
   assign mem_wdata = wdata_raw;
   assign par_err   = 1'b0;
`endif

   imem_array #(
      .WIDTH  (MW),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   assign bus.ld_ready     = (state_q == ST_LOAD);
   assign bus.busy         = (state_q != ST_RUN);
   assign bus.fetch_ready  = (state_q == ST_RUN);
   assign bus.ld_ovf       = ld_ovf_q;
   assign bus.words_loaded = words_loaded_q;
   assign bus.rvalid       = rvalid_q;
   assign bus.rdata        = (oob_q | par_err) ? NOP_WORD : mem_rdata[ISIZE-1:0];
   assign bus.fetch_err    = rvalid_q & (oob_q | par_err);
endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - directed bench for imem_loadable with DEPTH 256, 200 and 4 instances
module tb_imem_loadable;
   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NDUT-1:0]       ld_start_s    = '0;
   logic [NDUT-1:0]       ld_valid_s    = '0;
   logic [NDUT-1:0]       ld_last_s     = '0;
   logic [NDUT-1:0]       fetch_valid_s = '0;
   logic [NDUT-1:0][15:0] ld_data_s     = '0;
   logic [NDUT-1:0][7:0]  fetch_addr_s  = '0;
   logic [NDUT-1:0]       ld_ready_s, ld_ovf_s, busy_s, fetch_ready_s, rvalid_s, fetch_err_s;
   logic [NDUT-1:0][8:0]  wl_s;
   logic [NDUT-1:0][15:0] rdata_s;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int D = (g == 0) ? 256 : (g == 1) ? 200 : 4;
      imem_loadable_if #(.ISIZE(16), .ADDR_W(8)) bus ();
      assign bus.ld_start    = ld_start_s[g];
      assign bus.ld_valid    = ld_valid_s[g];
      assign bus.ld_last     = ld_last_s[g];
      assign bus.ld_data     = ld_data_s[g];
      assign bus.fetch_valid = fetch_valid_s[g];
      assign bus.fetch_addr  = fetch_addr_s[g];
      assign ld_ready_s[g]    = bus.ld_ready;
      assign ld_ovf_s[g]      = bus.ld_ovf;
      assign busy_s[g]        = bus.busy;
      assign fetch_ready_s[g] = bus.fetch_ready;
      assign rvalid_s[g]      = bus.rvalid;
      assign fetch_err_s[g]   = bus.fetch_err;
      assign wl_s[g]          = bus.words_loaded;
      assign rdata_s[g]       = bus.rdata;
      imem_loadable #(.ISIZE(16), .ADDR_W(8), .DEPTH(D), .NOP_WORD(16'h0000)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          d;
      logic [7:0]  addr;
      logic [15:0] exp_rd;
      logic        exp_err;
   } fvec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_fetch(input int d, input logic [7:0] a,
                           output logic rv, output logic [15:0] rd, output logic er);
      fetch_valid_s[d] = 1'b1;
      fetch_addr_s[d]  = a;
      @(negedge clk);
      fetch_valid_s[d] = 1'b0;
      rv = rvalid_s[d];
      rd = rdata_s[d];
      er = fetch_err_s[d];
   endtask

   task automatic count_clear(input int d, input bit to_load, input int exp, input string name);
      int n = 0;
      while ((to_load ? !ld_ready_s[d] : busy_s[d]) && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'(exp));
   endtask

   task automatic load_prog(input int d, input int n, input logic [15:0] beats[8], input int depth,
                            input int exp_wl, input bit exp_ovf, input string name);
      ld_start_s[d] = 1'b1;
      @(negedge clk);
      ld_start_s[d] = 1'b0;
      check({name, " busy after start"}, 32'(busy_s[d]), 32'd1);
      check({name, " wl cleared"}, 32'(wl_s[d]), 32'd0);
      check({name, " ovf cleared"}, 32'(ld_ovf_s[d]), 32'd0);
      count_clear(d, 1'b1, depth, {name, " clear cycles"});
      for (int i = 0; i < n; i++) begin
         ld_valid_s[d] = 1'b1;
         ld_data_s[d]  = beats[i];
         ld_last_s[d]  = (i == n - 1);
         @(negedge clk);
         if (i < n - 1) check($sformatf("%s busy beat %0d", name, i), 32'(busy_s[d]), 32'd1);
      end
      ld_valid_s[d] = 1'b0;
      ld_last_s[d]  = 1'b0;
      check({name, " busy after last"}, 32'(busy_s[d]), 32'd0);
      check({name, " fetch_ready"}, 32'(fetch_ready_s[d]), 32'd1);
      check({name, " words_loaded"}, 32'(wl_s[d]), 32'(exp_wl));
      check({name, " ld_ovf"}, 32'(ld_ovf_s[d]), 32'(exp_ovf));
   endtask

   initial begin
      fvec_t       tbl[$];
      logic [15:0] prog[8];
      int          cnt[NDUT];
      logic        rv, er;
      logic [15:0] rd;

      tbl.push_back('{0, 8'h00, 16'h1234, 1'b0});
      tbl.push_back('{0, 8'h01, 16'hABCD, 1'b0});
      tbl.push_back('{0, 8'h02, 16'h5A5A, 1'b0});
      tbl.push_back('{0, 8'h03, 16'h0000, 1'b0});
      tbl.push_back('{0, 8'h10, 16'h0000, 1'b0});
      tbl.push_back('{0, 8'hFF, 16'h0000, 1'b0});
      tbl.push_back('{1, 8'h00, 16'hBEEF, 1'b0});
      tbl.push_back('{1, 8'h01, 16'h0F0F, 1'b0});
      tbl.push_back('{1, 8'd199, 16'h0000, 1'b0});
      tbl.push_back('{1, 8'd200, 16'h0000, 1'b1});
      tbl.push_back('{1, 8'd210, 16'h0000, 1'b1});
      tbl.push_back('{2, 8'h00, 16'h1111, 1'b0});
      tbl.push_back('{2, 8'h01, 16'h2222, 1'b0});
      tbl.push_back('{2, 8'h02, 16'h3333, 1'b0});
      tbl.push_back('{2, 8'h03, 16'h4444, 1'b0});
      tbl.push_back('{2, 8'h04, 16'h0000, 1'b1});
      tbl.push_back('{2, 8'h05, 16'h0000, 1'b1});

      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy_s[0]), 32'd1);
      check("reset fetch_ready", 32'(fetch_ready_s[0]), 32'd0);
      check("reset ld_ready", 32'(ld_ready_s[0]), 32'd0);
      check("reset rvalid", 32'(rvalid_s[0]), 32'd0);
      check("reset fetch_err", 32'(fetch_err_s[0]), 32'd0);
      check("reset rdata", 32'(rdata_s[0]), 32'h0000);
      check("reset words_loaded", 32'(wl_s[0]), 32'd0);
      check("reset ld_ovf", 32'(ld_ovf_s[0]), 32'd0);

      rst = 1'b0;
      cnt = '{0, 0, 0};
      for (int i = 0; i < 300; i++) begin
         for (int d = 0; d < NDUT; d++) if (busy_s[d]) cnt[d]++;
         @(negedge clk);
      end
      check("A reset busy cycles", 32'(cnt[0]), 32'd256);
      check("B reset busy cycles", 32'(cnt[1]), 32'd200);
      check("C reset busy cycles", 32'(cnt[2]), 32'd4);
      check("A fetch_ready after clear", 32'(fetch_ready_s[0]), 32'd1);

      do_fetch(0, 8'h10, rv, rd, er);
      check("A first fetch rvalid", 32'(rv), 32'd1);
      check("A first fetch rdata", 32'(rd), 32'h0000);
      check("A first fetch err", 32'(er), 32'd0);
      @(negedge clk);
      check("A idle rvalid", 32'(rvalid_s[0]), 32'd0);

      prog = '{16'h1234, 16'hABCD, 16'h5A5A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      load_prog(0, 3, prog, 256, 3, 1'b0, "A load");
      prog = '{16'hBEEF, 16'h0F0F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      load_prog(1, 2, prog, 200, 2, 1'b0, "B load");
      prog = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0, 16'h0};
      load_prog(2, 6, prog, 4, 4, 1'b1, "C overflow load");

      ld_valid_s[0] = 1'b1;
      ld_data_s[0]  = 16'hFFFF;
      ld_last_s[0]  = 1'b1;
      @(negedge clk);
      ld_valid_s[0] = 1'b0;
      ld_last_s[0]  = 1'b0;
      check("A run ld_valid wl", 32'(wl_s[0]), 32'd3);
      check("A run ld_valid busy", 32'(busy_s[0]), 32'd0);

      foreach (tbl[i]) begin
         do_fetch(tbl[i].d, tbl[i].addr, rv, rd, er);
         check($sformatf("tbl%0d rvalid", i), 32'(rv), 32'd1);
         check($sformatf("tbl%0d rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
         check($sformatf("tbl%0d fetch_err", i), 32'(er), 32'(tbl[i].exp_err));
      end

      do_fetch(0, 8'h02, rv, rd, er);
      @(negedge clk);
      check("hold rvalid", 32'(rvalid_s[0]), 32'd0);
      check("hold rdata", 32'(rdata_s[0]), 32'h5A5A);
      check("hold fetch_err", 32'(fetch_err_s[0]), 32'd0);

      prog = '{16'h7777, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      load_prog(2, 1, prog, 4, 1, 1'b0, "C reload");
      do_fetch(2, 8'h00, rv, rd, er);
      check("C reload word0", 32'(rd), 32'h7777);
      do_fetch(2, 8'h01, rv, rd, er);
      check("C reload word1 cleared", 32'(rd), 32'h0000);

`ifdef IMEM_PARITY_EN
      g_dut[0].u_dut.u_array.mem[1][0] = ~g_dut[0].u_dut.u_array.mem[1][0];
      do_fetch(0, 8'h01, rv, rd, er);
      check("parity rvalid", 32'(rv), 32'd1);
      check("parity rdata", 32'(rd), 32'h0000);
      check("parity fetch_err", 32'(er), 32'd1);
`else
      do_fetch(0, 8'h01, rv, rd, er);
      check("no parity rdata", 32'(rd), 32'hABCD);
      check("no parity fetch_err", 32'(er), 32'd0);
`endif

      fetch_valid_s[0] = 1'b1;
      fetch_addr_s[0]  = 8'h00;
      ld_start_s[0]    = 1'b1;
      @(negedge clk);
      fetch_valid_s[0] = 1'b0;
      ld_start_s[0]    = 1'b0;
      check("simul rvalid", 32'(rvalid_s[0]), 32'd1);
      check("simul rdata", 32'(rdata_s[0]), 32'h1234);
      check("simul fetch_err", 32'(fetch_err_s[0]), 32'd0);
      check("simul busy", 32'(busy_s[0]), 32'd1);
      count_clear(0, 1'b1, 256, "A simul clear cycles");

      ld_valid_s[0] = 1'b1;
      ld_data_s[0]  = 16'hCAFE;
      @(negedge clk);
      ld_data_s[0]  = 16'hF00D;
      @(negedge clk);
      ld_valid_s[0] = 1'b0;
      check("A partial wl", 32'(wl_s[0]), 32'd2);
      check("A partial busy", 32'(busy_s[0]), 32'd1);

      rst = 1'b1;
      @(negedge clk);
      check("A mid-load reset busy", 32'(busy_s[0]), 32'd1);
      check("A mid-load reset wl", 32'(wl_s[0]), 32'd0);
      check("A mid-load reset ld_ready", 32'(ld_ready_s[0]), 32'd0);
      rst = 1'b0;
      count_clear(0, 1'b0, 256, "A mid-load reset clear cycles");
      do_fetch(0, 8'h00, rv, rd, er);
      check("A after reset word0", 32'(rd), 32'h0000);
      check("A after reset rvalid", 32'(rv), 32'd1);
      do_fetch(0, 8'h01, rv, rd, er);
      check("A after reset word1", 32'(rd), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
